// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a fetch port (read-only) and a data port (read/write) onto a
//   single shared memory request/acknowledge bus.
//   - The data port normally wins. After STARVE_LIMIT data grants in a row
//     with a fetch request waiting, the fetch port wins once.
//   - A granted transaction holds every mem_* field until mem_ack_i arrives.
//     If no mem_ack_i arrives within TIMEOUT cycles, the transaction is
//     aborted and completes with err_o=1.
//   - The requester sees a one-cycle ack with read data, two cycles after
//     the memory acknowledge.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   if_req_i/if_addr_i            fetch request and address
//   if_ack_o/if_rdata_o           fetch completion pulse and data
//   dm_req_i/dm_we_i/dm_addr_i/
//   dm_wdata_i/dm_wstrb_i         data request, direction, address, payload
//   dm_ack_o/dm_rdata_o           data completion pulse and read data
//   err_o                         timeout abort flag, valid with either ack
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_wstrb_o       shared memory request bus
//   mem_ack_i/mem_rdata_i         memory completion pulse and read data
//   busy_o                        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_wstrb_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  // Width large enough to hold STARVE_LIMIT itself (saturation value).
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_gnt_dm;     // 1 = current transaction belongs to data port
  logic          r_err_pend;   // transaction ended by timeout
  logic [SW-1:0] r_starve_cnt;
  logic [7:0]    r_tmo_cnt;
  logic [31:0]   r_rdata;      // data captured from memory on completion

  logic          r_mem_req;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;

  logic          r_if_ack;
  logic          r_dm_ack;
  logic          r_err;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_dm_rdata;

  logic          w_ack_out;
  logic          w_pick_if;
  logic          w_tmo_hit;

  // The requester still holds its request during its own ack cycle, so IDLE
  // must not sample requests while an ack is on the outputs.
  assign w_ack_out = r_if_ack | r_dm_ack;
  assign w_pick_if = if_req_i && (!dm_req_i || (r_starve_cnt == SW'(STARVE_LIMIT)));
  assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT - 1));

  // NOTE: every register, including captured data and counters, is cleared
  // asynchronously; state updates use non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_gnt_dm     <= 1'b0;
      r_err_pend   <= 1'b0;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_rdata      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      // Response outputs are single-cycle pulses unless RESP sets them.
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;

      case (r_state)
        IDLE: begin
          if (!w_ack_out && (if_req_i || dm_req_i)) begin
            r_mem_req <= 1'b1;
            r_tmo_cnt <= '0;
            if (w_pick_if) begin
              r_state      <= GNT_IF;
              r_gnt_dm     <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= if_addr_i;
              r_mem_wdata  <= '0;
              r_mem_wstrb  <= '0;
              r_starve_cnt <= '0;
            end else begin
              r_state     <= GNT_DM;
              r_gnt_dm    <= 1'b1;
              r_mem_we    <= dm_we_i;
              r_mem_addr  <= dm_addr_i;
              r_mem_wdata <= dm_wdata_i;
              r_mem_wstrb <= dm_wstrb_i;
              // Only count grants that actually made the fetch port wait.
              if (if_req_i && (r_starve_cnt != SW'(STARVE_LIMIT)))
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
          end
        end

        GNT_IF, GNT_DM: begin
          // An ack on the expiry cycle is checked first, so it wins.
          if (mem_ack_i || w_tmo_hit) begin
            r_state     <= RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_err_pend  <= !mem_ack_i;
            r_rdata     <= (mem_ack_i && !r_mem_we) ? mem_rdata_i : '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        RESP: begin
          r_state    <= IDLE;
          r_if_ack   <= !r_gnt_dm;
          r_dm_ack   <= r_gnt_dm;
          r_err      <= r_err_pend;
          r_if_rdata <= r_gnt_dm ? '0 : r_rdata;
          r_dm_rdata <= r_gnt_dm ? r_rdata : '0;
          r_err_pend <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign dm_ack_o    = r_dm_ack;
  assign dm_rdata_o  = r_dm_rdata;
  assign err_o       = r_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wstrb_o = r_mem_wstrb;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Directed scenarios (fetch read,
//   delayed data write, starvation pattern, timeout, reset mid-transaction)
//   followed by randomized traffic. Expected grant order comes from a
//   transaction-level starvation counter; expected timing and data come from
//   the request-to-ack latency rules expressed as plain cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 255;
  localparam int NTX   = 80;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wstrb_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int m_starve;   // consecutive data wins seen while a fetch was waiting

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i     = 1'b0;
    if_req_i  = 1'b0; if_addr_i  = '0;
    dm_req_i  = 1'b0; dm_we_i    = 1'b0; dm_addr_i = '0;
    dm_wdata_i = '0;  dm_wstrb_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #1;
    step();
    step();
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_busy",    32'(busy_o), 32'd0);
    check("rst_acks",    32'({if_ack_o, dm_ack_o, err_o}), 32'd0);
    check("rst_addr",    mem_addr_o, 32'd0);
    check("rst_rdata",   if_rdata_o | dm_rdata_o, 32'd0);
    rst_i    = 1'b1;
    m_starve = 0;
  endtask

  // Called at the cycle N in which the DUT (in IDLE) samples the requests.
  // Memory acks d cycles after the first mem_req_o cycle; d >= TMO means
  // never. Returns just after the requester's ack cycle.
  task automatic run_txn(input bit is_dm, input int d, input logic [31:0] rd,
                         input bit late_ack);
    logic [31:0] ea, ew, exp_rd;
    logic [3:0]  es;
    logic        ewe;
    bit          tmo;
    int          n_gnt;
    if (is_dm) begin
      ea = dm_addr_i; ewe = dm_we_i; ew = dm_wdata_i; es = dm_wstrb_i;
    end else begin
      ea = if_addr_i; ewe = 1'b0;    ew = '0;         es = '0;
    end
    tmo    = (d >= TMO);
    n_gnt  = tmo ? TMO : d + 1;
    exp_rd = (!tmo && !ewe) ? rd : 32'd0;

    for (int c = 0; c < n_gnt; c++) begin
      step();
      check("gnt_mem_req", 32'(mem_req_o), 32'd1);
      check("gnt_addr",    mem_addr_o, ea);
      check("gnt_we",      32'(mem_we_o), 32'(ewe));
      check("gnt_wdata",   mem_wdata_o, ew);
      check("gnt_wstrb",   32'(mem_wstrb_o), 32'(es));
      check("gnt_busy",    32'(busy_o), 32'd1);
      check("gnt_no_ack",  32'({if_ack_o, dm_ack_o}), 32'd0);
      mem_ack_i   = (c == d);
      mem_rdata_i = (c == d) ? rd : $urandom;
    end

    step();  // RESP
    mem_ack_i   = late_ack;
    mem_rdata_i = $urandom;
    check("resp_mem_req", 32'(mem_req_o), 32'd0);
    check("resp_busy",    32'(busy_o), 32'd1);
    check("resp_no_ack",  32'({if_ack_o, dm_ack_o}), 32'd0);

    step();  // ack cycle
    mem_ack_i = late_ack;
    check("ack_if",    32'(if_ack_o), 32'(!is_dm));
    check("ack_dm",    32'(dm_ack_o), 32'(is_dm));
    check("ack_rdata", is_dm ? dm_rdata_o : if_rdata_o, exp_rd);
    check("ack_err",   32'(err_o), 32'(tmo));
    check("ack_busy",  32'(busy_o), 32'd0);
    check("ack_mreq",  32'(mem_req_o), 32'd0);
  endtask

  // Cycle after an ack: pulse must be gone and no stray ack may appear.
  task automatic post_ack();
    step();
    mem_ack_i = 1'b0;
    check("post_no_ack", 32'({if_ack_o, dm_ack_o, err_o}), 32'd0);
  endtask

  bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    // Fetch read, immediate memory ack.
    reset_dut();
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    run_txn(1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    if_req_i = 1'b0;
    post_ack();

    // Data write acked after 3 cycles: fields held for 4 cycles.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200;
    dm_wdata_i = 32'h1234_5678; dm_wstrb_i = 4'h3;
    run_txn(1'b1, 3, 32'hFFFF_FFFF, 1'b0);
    dm_req_i = 1'b0;
    post_ack();

    // Starvation: both held continuously, memory acks at once.
    reset_dut();
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2000;
    for (int k = 0; k < 10; k++) begin
      run_txn(exp_seq[k], 0, 32'h5000 + 32'(k), 1'b0);
      post_ack();
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    step();

    // Timeout: data read never acked, then a late ack must be ignored.
    reset_dut();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    run_txn(1'b1, 1000, 32'hAAAA_5555, 1'b1);
    dm_req_i = 1'b0;
    post_ack();
    check("late_busy", 32'(busy_o), 32'd0);

    // Reset two cycles into GNT_IF, then a fresh grant after release.
    if_req_i = 1'b1; if_addr_i = 32'h400;
    step();
    check("pre_rst_mreq", 32'(mem_req_o), 32'd1);
    step();
    rst_i = 1'b0;
    #1;
    check("midrst_mreq", 32'(mem_req_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    step();
    check("midrst_no_ack", 32'(if_ack_o), 32'd0);
    step();
    check("midrst_no_ack2", 32'(if_ack_o), 32'd0);
    rst_i    = 1'b1;
    m_starve = 0;
    if_addr_i = 32'h480;
    run_txn(1'b0, 1, 32'hCAFE_F00D, 1'b0);
    if_req_i = 1'b0;
    post_ack();

    // Randomized traffic.
    for (int t = 0; t < NTX; ) begin
      bit is_dm;
      int r, d;
      if (!if_req_i && $urandom_range(0, 1) == 1) begin
        if_req_i  = 1'b1;
        if_addr_i = $urandom;
      end
      if (!dm_req_i && $urandom_range(0, 1) == 1) begin
        dm_req_i   = 1'b1;
        dm_we_i    = 1'($urandom_range(0, 1));
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
        dm_wstrb_i = 4'($urandom_range(0, 15));
      end
      mem_ack_i = ($urandom_range(0, 3) == 0);  // stray ack while idle
      if (!if_req_i && !dm_req_i) begin
        step();
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_mreq", 32'(mem_req_o), 32'd0);
        continue;
      end
      // Data wins unless the fetch port has waited LIMIT data grants.
      is_dm = dm_req_i && !(if_req_i && m_starve == LIMIT);
      if (!is_dm)        m_starve = 0;
      else if (if_req_i) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      r = $urandom_range(0, 29);
      d = (r == 0) ? 300 : (r == 1) ? TMO - 1 : $urandom_range(0, 4);
      run_txn(is_dm, d, $urandom, 1'($urandom_range(0, 1)));
      if (is_dm) dm_req_i = 1'b0;
      else       if_req_i = 1'b0;
      post_ack();
      t++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
